instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch-side requester for the 2048-entry instruction memory, which has a registered 1-cycle read. It holds the program counter, drives the memory address, captures the returned word, and presents it to the core over a valid/ready handshake, already split into a 5-bit opcode and a 12-bit operand. It handles PC redirects for taken branches (jpnz/jmpz), stops on endop, and counts retired fetches.

Parameters:
ADDR_W, 11, PC and memory address width (2048 words)
INSTR_W, 17, instruction width ({opcode[16:12], operand[11:0]})
START_ADDR, 0, PC value loaded on reset and on start
ENDOP, 5'd31, opcode value that halts fetch

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin fetching from START_ADDR; honoured only in IDLE or HALT
mem_addr  output  ADDR_W  address to instruction memory; equals pc register
mem_instr  input  INSTR_W  memory read data; valid the cycle after mem_addr is presented
ir_valid  output  1  ir/opcode/operand hold a valid instruction
ir_ready  input  1  core accepts the instruction this cycle
ir  output  INSTR_W  captured instruction word
opcode  output  5  ir[16:12]
operand  output  12  ir[11:0]
redirect_en  input  1  branch taken; sampled only together with an accepted handshake
redirect_addr  input  12  branch target; low ADDR_W bits used
pc  output  ADDR_W  address of the instruction currently in, or being fetched into, ir
halted  output  1  high in HALT
fetch_count  output  16  accepted instructions since start; saturates at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=START_ADDR, ir=0, ir_valid=0, halted=0, fetch_count=0. mem_addr follows pc. Reset mid-fetch discards any in-flight word.
- States: IDLE, REQ, CAPT, HOLD, HALT.
- IDLE: start=1 -> pc=START_ADDR, fetch_count=0, next state REQ. Otherwise remain in IDLE.
- REQ: mem_addr=pc is presented and the memory registers it. Next state is always CAPT.
- CAPT: mem_instr is valid. ir<=mem_instr and ir_valid<=1. Next state is HOLD.
- HOLD: ir_valid=1. ir, opcode and operand stay stable until accepted.
- Accept is the cycle in which ir_valid=1 and ir_ready=1. On accept: ir_valid<=0 and fetch_count increments (saturating).
- On accept with opcode==ENDOP: next state HALT, pc unchanged, redirect_en ignored.
- On accept with redirect_en=1: pc<=redirect_addr[ADDR_W-1:0] (MSB dropped when ADDR_W<12), next state REQ.
- On accept otherwise: pc<=pc+1, wrapping 2^ADDR_W-1 -> 0, next state REQ.
- redirect_en without an accept is ignored.
- Latency: REQ at cycle N, CAPT at N+1, ir_valid=1 from N+2. Minimum 3 cycles per instruction when ir_ready is held high.
- HALT: halted=1, ir_valid=0, pc holds the endop address. start=1 re-enters REQ from START_ADDR, clears halted and fetch_count.
- start in REQ, CAPT or HOLD is ignored.
- opcode and operand are combinational slices of ir. No other decoding is done here; the core interprets all opcodes other than ENDOP.

Test Plan:
- Reset then start, ram[0]=17'h1E000 (clac), ir_ready=1 -> mem_addr=0 in cycle 1, ir_valid=1 in cycle 3 with opcode=30, operand=0; pc=1 after accept; fetch_count=1.
- Backpressure: hold ir_ready=0 for 5 cycles in HOLD -> ir stays stable, pc stays, fetch_count unchanged; accepted on the first cycle ir_ready=1.
- Branch: accept ram[31]=17'h18000 (jpnz 0) with redirect_en=1, redirect_addr=12'd2 -> next mem_addr=2. Repeat with redirect_en=0 -> next mem_addr=32.
- Halt: accept 17'h1F000 (endop) with redirect_en=1 -> halted=1, pc unchanged, no further REQ. Then start=1 -> refetch from 0, fetch_count=0.
- Wrap/truncation: pc=2047 accepted without redirect -> pc=0. redirect_addr=12'd4094 -> pc=2046.
- Async reset asserted during CAPT -> all outputs take reset values immediately; no stale ir_valid after rst_n deasserts.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch requester with valid/ready hand-off and branch redirect
module instr_fetch #(
  parameter int                ADDR_W     = 11,
  parameter int                INSTR_W    = 17,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [4:0]        ENDOP      = 5'd31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [4:0]         opcode,
  output logic [11:0]        operand,
  input  logic               redirect_en,
  input  logic [11:0]        redirect_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   is_endop;

  assign opcode   = ir[INSTR_W-1 -: 5];
  assign operand  = ir[11:0];
  assign mem_addr = pc;
  assign halted   = (state == S_HALT);
  assign accept   = ir_valid && ir_ready;
  assign is_endop = (opcode == ENDOP);

  // Branch targets wider than the memory simply lose their upper bits.
  generate
    if (ADDR_W < 12) begin : g_redir_trunc
      logic unused_redirect_msbs;
      assign unused_redirect_msbs = ^redirect_addr[11:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_HOLD;
      S_HOLD:  if (accept) state_nxt = is_endop ? S_HALT : S_REQ;
      S_HALT:  if (start) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= START_ADDR;
      ir          <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc          <= START_ADDR;
            fetch_count <= '0;
          end
        end
        S_CAPT: begin
          ir       <= mem_instr;
          ir_valid <= 1'b1;
        end
        S_HOLD: begin
          if (accept) begin
            ir_valid <= 1'b0;
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            // endop parks pc on its own address and ignores any redirect
            if (!is_endop) begin
              pc <= redirect_en ? redirect_addr[ADDR_W-1:0] : pc + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 17;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_instr = '0;
  logic               ir_valid;
  logic               ir_ready = 1'b0;
  logic [INSTR_W-1:0] ir;
  logic [4:0]         opcode;
  logic [11:0]        operand;
  logic               redirect_en = 1'b0;
  logic [11:0]        redirect_addr = '0;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic [15:0]        fetch_count;

  logic [INSTR_W-1:0] ram [0:2047];

  int errors = 0;
  int checks = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_instr(mem_instr),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .opcode(opcode), .operand(operand),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .pc(pc), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_instr <= ram[mem_addr];

  typedef struct {
    logic [10:0] at_pc;
    logic [16:0] instr;
    logic        ren;
    logic [11:0] raddr;
    logic [4:0]  exp_opc;
    logic [11:0] exp_opr;
    logic [10:0] exp_pc;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ir_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: ir_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic do_accept(input logic ren, input logic [11:0] raddr);
    ir_ready = 1'b1; redirect_en = ren; redirect_addr = raddr;
    @(negedge clk);
    ir_ready = 1'b0; redirect_en = 1'b0;
  endtask

  task automatic goto_pc(input logic [10:0] target);
    do_reset();
    ram[0] = 17'h00000;
    pulse_start();
    wait_valid("goto_valid");
    do_accept(1'b1, {1'b0, target});
  endtask

  // Random phase: the model walks the program by the fetch rules directly.
  task automatic random_run(input int ncycles);
    logic [10:0] m_pc = '0;
    int          m_cnt = 0;
    bit          m_halt = 1'b0;
    bit          m_run = 1'b0;
    int          idle = 0;
    logic [16:0] word;
    for (int i = 0; i < 2048; i++) begin
      word[16:12] = ($urandom_range(0, 40) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      word[11:0]  = 12'($urandom);
      ram[i] = word;
    end
    do_reset();
    for (int c = 0; c < ncycles; c++) begin
      check("rnd_pc", 32'(pc), 32'(m_pc));
      check("rnd_halted", 32'(halted), 32'(m_halt));
      check("rnd_count", 32'(fetch_count), 32'(m_cnt));
      if (ir_valid) check("rnd_ir", 32'(ir), 32'(ram[m_pc]));
      if (m_halt || !m_run) check("rnd_no_valid", 32'(ir_valid), 32'(0));
      if (m_run && !m_halt && !ir_valid) idle++; else idle = 0;
      check("rnd_latency_ok", 32'(idle <= 2), 32'(1));

      start = 1'b0;
      ir_ready = ($urandom_range(0, 2) != 0);
      redirect_en = ($urandom_range(0, 3) == 0);
      redirect_addr = 12'($urandom);
      if (m_halt || !m_run) begin
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          m_pc = '0; m_cnt = 0; m_halt = 1'b0; m_run = 1'b1;
        end
      end else begin
        if ($urandom_range(0, 9) == 0) start = 1'b1;
        if (ir_valid && ir_ready) begin
          if (m_cnt < 65535) m_cnt++;
          if (ram[m_pc][16:12] == 5'd31) m_halt = 1'b1;
          else if (redirect_en) m_pc = redirect_addr[10:0];
          else m_pc = 11'((int'(m_pc) + 1) % 2048);
        end
      end
      @(negedge clk);
    end
    start = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0;
  endtask

  initial begin
    logic [16:0] held;
    for (int i = 0; i < 2048; i++) ram[i] = '0;

    vecs[0] = '{11'd31,   17'h18000, 1'b1, 12'd2,    5'd24, 12'h000, 11'd2,    1'b0};
    vecs[1] = '{11'd31,   17'h18000, 1'b0, 12'd2,    5'd24, 12'h000, 11'd32,   1'b0};
    vecs[2] = '{11'd2047, 17'h05123, 1'b0, 12'd9,    5'd5,  12'h123, 11'd0,    1'b0};
    vecs[3] = '{11'd5,    17'h18000, 1'b1, 12'd4094, 5'd24, 12'h000, 11'd2046, 1'b0};
    vecs[4] = '{11'd7,    17'h1F000, 1'b1, 12'd9,    5'd31, 12'h000, 11'd7,    1'b1};
    vecs[5] = '{11'd100,  17'h1E7AB, 1'b0, 12'd0,    5'd30, 12'h7AB, 11'd101,  1'b0};

    // Reset values, first fetch latency, first accept
    do_reset();
    check("rst_ir_valid", 32'(ir_valid), 32'(0));
    check("rst_ir", 32'(ir), 32'(0));
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_count", 32'(fetch_count), 32'(0));
    ram[0] = 17'h1E000;
    ram[1] = 17'h02345;
    ir_ready = 1'b1;
    pulse_start();
    check("c1_mem_addr", 32'(mem_addr), 32'(0));
    check("c1_ir_valid", 32'(ir_valid), 32'(0));
    @(negedge clk);
    check("c2_ir_valid", 32'(ir_valid), 32'(0));
    @(negedge clk);
    check("c3_ir_valid", 32'(ir_valid), 32'(1));
    check("c3_opcode", 32'(opcode), 32'(30));
    check("c3_operand", 32'(operand), 32'(0));
    @(negedge clk);
    ir_ready = 1'b0;
    check("acc1_pc", 32'(pc), 32'(1));
    check("acc1_count", 32'(fetch_count), 32'(1));
    check("acc1_ir_valid", 32'(ir_valid), 32'(0));

    // Backpressure with an ignored redirect and an ignored start
    wait_valid("bp_valid");
    held = ir;
    check("bp_ir", 32'(held), 32'(17'h02345));
    for (int i = 0; i < 5; i++) begin
      redirect_en = 1'b1; redirect_addr = 12'd77; start = 1'b1;
      @(negedge clk);
      check("bp_stable_ir", 32'(ir), 32'(held));
      check("bp_stable_valid", 32'(ir_valid), 32'(1));
      check("bp_stable_pc", 32'(pc), 32'(1));
      check("bp_stable_count", 32'(fetch_count), 32'(1));
    end
    start = 1'b0;
    do_accept(1'b0, 12'd0);
    check("bp_acc_pc", 32'(pc), 32'(2));
    check("bp_acc_count", 32'(fetch_count), 32'(2));

    // Table-driven: branch, fall-through, wrap, truncation, endop
    for (int v = 0; v < 6; v++) begin
      ram[vecs[v].at_pc] = vecs[v].instr;
      goto_pc(vecs[v].at_pc);
      wait_valid("vec_valid");
      check("vec_pc_before", 32'(pc), 32'(vecs[v].at_pc));
      check("vec_opcode", 32'(opcode), 32'(vecs[v].exp_opc));
      check("vec_operand", 32'(operand), 32'(vecs[v].exp_opr));
      do_accept(vecs[v].ren, vecs[v].raddr);
      check("vec_pc_after", 32'(pc), 32'(vecs[v].exp_pc));
      check("vec_halted", 32'(halted), 32'(vecs[v].exp_halt));
      check("vec_ir_valid", 32'(ir_valid), 32'(0));
      check("vec_count", 32'(fetch_count), 32'(2));
      @(negedge clk);
      check("vec_mem_addr", 32'(mem_addr), 32'(vecs[v].exp_pc));
      if (vecs[v].exp_halt) begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("halt_no_valid", 32'(ir_valid), 32'(0));
          check("halt_pc", 32'(pc), 32'(vecs[v].exp_pc));
          check("halt_halted", 32'(halted), 32'(1));
        end
        pulse_start();
        check("restart_mem_addr", 32'(mem_addr), 32'(0));
        check("restart_halted", 32'(halted), 32'(0));
        check("restart_count", 32'(fetch_count), 32'(0));
        wait_valid("restart_valid");
        check("restart_ir", 32'(ir), 32'(17'h00000));
      end
    end

    // Async reset while a word is in flight
    do_reset();
    ram[0]  = 17'h0ABCD;
    ram[50] = 17'h01111;
    pulse_start();
    wait_valid("ar_valid");
    do_accept(1'b1, 12'd50);
    check("ar_pc50", 32'(pc), 32'(50));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc", 32'(pc), 32'(0));
    check("ar_mem_addr", 32'(mem_addr), 32'(0));
    check("ar_ir", 32'(ir), 32'(0));
    check("ar_ir_valid", 32'(ir_valid), 32'(0));
    check("ar_count", 32'(fetch_count), 32'(0));
    check("ar_halted", 32'(halted), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ar_idle_valid", 32'(ir_valid), 32'(0));
      check("ar_idle_addr", 32'(mem_addr), 32'(0));
    end

    random_run(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
